// File: rtl/dsd_pkg.sv
// Shared controller definitions: FSM encodings and the default operand width.
package dsd_pkg;

  localparam int DEF_WIDTH = 8;

  // Code 2'd3 is unused; the controller recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subt_ctrl_cell.sv
// Half subtractor: purely combinational one-bit difference/borrow.
// Latency: 0 cycles.
// Backpressure: none, combinational.
module Half_subt (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

// Full subtractor cell: two chained half subtractors plus an OR of the borrows.
// Latency: 0 cycles.
// Backpressure: none, combinational.
module full_subt_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d0;
  logic b0;
  logic b1;

  Half_subt u_hs0 (.x(x),  .y(y),   .d(d0), .b(b0));
  Half_subt u_hs1 (.x(d0), .y(bin), .d(d),  .b(b1));

  assign bo = b0 | b1;
endmodule

// File: rtl/serial_subt_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b) sharing one full-subtractor cell.
// Latency: WIDTH+1 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; a start during DONE is accepted back-to-back.
module serial_subt_ctrl
  import dsd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             bff;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bo;

  full_subt_cell u_cell (
    .x   (sa[0]),
    .y   (sb[0]),
    .bin (bff),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      bff        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            bff   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {cell_d, sr[WIDTH-1:1]};
          bff <= cell_bo;
          // Last bit: publish the completed word straight from the cell output.
          if (cnt == LAST) begin
            cnt        <= '0;
            diff       <= {cell_d, sr[WIDTH-1:1]};
            borrow_out <= cell_bo;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
